// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared fetch-side types, widths and defaults for the instruction prefetch buffer.
package instr_prefetch_buffer_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  typedef enum logic [0:0] {
    StIdle,
    StWaitGnt
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
    return addr & INSTR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Instruction-side bus: req/addr held until gnt, in-order rvalid responses.
interface instr_prefetch_buffer_if;
  import instr_prefetch_buffer_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage flops, no bypass.
module instr_prefetch_buffer_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CntW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetcher: issues credit-limited bus requests, buffers kept responses in a
// FIFO and drops responses that became stale through a redirect.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = DEFAULT_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [XLEN-1:0]                boot_addr_i,
  input  logic                           redirect_i,
  input  logic [XLEN-1:0]                redirect_addr_i,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic [XLEN-1:0]                rdata_o,
  output logic [XLEN-1:0]                addr_o,
  output logic                           err_o,
  output logic                           busy_o,
  instr_prefetch_buffer_if.master        instr
);

  localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FifoCntW = $clog2(DEPTH + 1);
  localparam int unsigned EntryW   = 2 * XLEN + 1;

  fetch_state_e        state_q, state_d;
  logic [XLEN-1:0]     fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0]     target_q, target_d;
  logic [XLEN-1:0]     resp_addr_q, resp_addr_d;
  logic                stale_q, stale_d;
  logic [OutW-1:0]     live_q, live_d, discard_q, discard_d;
  logic [FifoCntW-1:0] fifo_count;
  logic                granted, drop, push, pop, credit;
  logic [XLEN-1:0]     push_rdata;
  logic [EntryW-1:0]   push_entry, head_entry;
  int unsigned         count_next, live_next, discard_next;

  assign instr.req  = (state_q == StWaitGnt);
  assign instr.addr = fetch_addr_q;

  assign granted    = instr.req && instr.gnt;
  // Responses in the redirect cycle are stale whatever the counters say.
  assign drop       = instr.rvalid && (redirect_i || (discard_q != '0));
  assign push       = instr.rvalid && !drop;
  assign pop        = valid_o && ready_i && !redirect_i;
  assign push_rdata = instr.err ? '0 : instr.rdata;
  assign push_entry = {push_rdata, instr.err, resp_addr_q};

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    resp_addr_d  = resp_addr_q;
    stale_d      = stale_q;
    live_next    = 32'(live_q);
    discard_next = 32'(discard_q);
    count_next   = 32'(fifo_count);

    if (redirect_i) begin
      // Everything in flight, plus a grant landing now, becomes stale.
      discard_next = discard_next + live_next + 32'(granted) - 32'(instr.rvalid);
      live_next    = 0;
      count_next   = 0;
      resp_addr_d  = align_addr(redirect_addr_i);
      if (instr.req && !instr.gnt) begin
        stale_d  = 1'b1;
        target_d = align_addr(redirect_addr_i);
      end else begin
        stale_d      = 1'b0;
        fetch_addr_d = align_addr(redirect_addr_i);
      end
    end else begin
      if (granted) begin
        if (stale_q) begin
          discard_next = discard_next + 1;
          fetch_addr_d = target_q;
          stale_d      = 1'b0;
        end else begin
          live_next    = live_next + 1;
          fetch_addr_d = fetch_addr_q + 32'd4;
        end
      end
      if (drop) begin
        discard_next = discard_next - 1;
      end
      if (push) begin
        live_next   = live_next - 1;
        resp_addr_d = resp_addr_q + 32'd4;
        count_next  = count_next + 1;
      end
      if (pop) begin
        count_next = count_next - 1;
      end
    end

    credit = (count_next + live_next < DEPTH) && (live_next + discard_next < MAX_OUTSTANDING);
    live_d    = OutW'(live_next);
    discard_d = OutW'(discard_next);

    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = credit ? StWaitGnt : StIdle;
      StWaitGnt: if (instr.gnt) state_d = credit ? StWaitGnt : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      fetch_addr_q <= align_addr(boot_addr_i);
      target_q     <= '0;
      resp_addr_q  <= align_addr(boot_addr_i);
      stale_q      <= 1'b0;
      live_q       <= '0;
      discard_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      resp_addr_q  <= resp_addr_d;
      stale_q      <= stale_d;
      live_q       <= live_d;
      discard_q    <= discard_d;
    end
  end

  instr_prefetch_buffer_fifo #(
    .WIDTH(EntryW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .flush_i(redirect_i),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .rdata_o(head_entry),
    .valid_o(valid_o),
    .count_o(fifo_count)
  );

  assign {rdata_o, err_o, addr_o} = head_entry;
  assign busy_o = instr.req || (live_q != '0) || (discard_q != '0);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: per-cycle vector table plus corner sequences
// against a simple in-order memory responder (data = addr + 0x1000_0000).
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n, redirect, ready;
  logic [31:0] boot_addr, redirect_addr;
  logic        valid, err, busy;
  logic [31:0] rdata, head_addr;
  logic        gnt_en, resp_en;
  logic [31:0] err_addr;
  logic [31:0] rsp_q [$];
  int          total = 0;
  int          bad = 0;

  typedef struct packed {
    logic        exp_req;
    logic [31:0] exp_bus_addr;
    logic        exp_valid;
    logic [31:0] exp_head;
    logic        exp_busy;
    logic        nxt_ready;
    logic        nxt_gnt_en;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  instr_prefetch_buffer_if bus ();

  instr_prefetch_buffer dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .boot_addr_i    (boot_addr),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .ready_i        (ready),
    .valid_o        (valid),
    .rdata_o        (rdata),
    .addr_o         (head_addr),
    .err_o          (err),
    .busy_o         (busy),
    .instr          (bus)
  );

  assign bus.gnt = bus.req & gnt_en;

  // Grant is queued first, so a response can follow its grant by exactly one cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      rsp_q.delete();
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.err    <= 1'b0;
    end else begin
      if (bus.req && bus.gnt) rsp_q.push_back(bus.addr);
      bus.rvalid <= 1'b0;
      if (resp_en && (rsp_q.size() != 0)) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rsp_q[0] + 32'h1000_0000;
        bus.err    <= (rsp_q[0] == err_addr);
        void'(rsp_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at a negedge with reset just released; the next posedge is the first live one.
  task automatic do_reset(input logic [31:0] boot);
    rst_n     = 1'b0;
    boot_addr = boot;
    redirect  = 1'b0;
    ready     = 1'b1;
    gnt_en    = 1'b1;
    resp_en   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_bus_addr", bus.addr, boot & 32'hFFFF_FFFC);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_head_addr", head_addr, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    ready         = 1'b1;
    gnt_en        = 1'b1;
    resp_en       = 1'b1;
    boot_addr     = '0;
    err_addr      = 32'h1;

    // Boot at 0x80: zero-wait start, gnt withheld on 0x84, then backpressure fills the FIFO.
    vecs[0]  = '{1'b1, 32'h80, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 32'h84, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h84, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h84, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h84, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 32'h88, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'h8C, 1'b1, 32'h84, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'h90, 1'b1, 32'h84, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h94, 1'b1, 32'h84, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h94, 1'b1, 32'h84, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 32'h94, 1'b1, 32'h88, 1'b1, 1'b1, 1'b1};

    do_reset(32'h80);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_req", i + 1), 32'(bus.req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_bus_addr", i + 1), bus.addr, vecs[i].exp_bus_addr);
      check($sformatf("vec%0d_valid", i + 1), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i + 1), 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_head_addr", i + 1), head_addr, vecs[i].exp_head);
        check($sformatf("vec%0d_rdata", i + 1), rdata, vecs[i].exp_head + 32'h1000_0000);
      end
      ready  = vecs[i].nxt_ready;
      gnt_en = vecs[i].nxt_gnt_en;
    end

    // Two granted requests in flight, redirect to 0x201: both responses must be dropped.
    do_reset(32'h90);
    resp_en = 1'b0;
    @(negedge clk);
    check("rdA_k1_addr", bus.addr, 32'h90);
    @(negedge clk);
    check("rdA_k2_addr", bus.addr, 32'h94);
    @(negedge clk);
    check("rdA_k3_req", 32'(bus.req), 32'h0);
    redirect      = 1'b1;
    redirect_addr = 32'h201;
    @(negedge clk);
    check("rdA_k4_req", 32'(bus.req), 32'h0);
    check("rdA_k4_bus_addr", bus.addr, 32'h200);
    check("rdA_k4_busy", 32'(busy), 32'h1);
    redirect = 1'b0;
    resp_en  = 1'b1;
    @(negedge clk);
    check("rdA_k5_req", 32'(bus.req), 32'h0);
    check("rdA_k5_valid", 32'(valid), 32'h0);
    @(negedge clk);
    check("rdA_k6_req", 32'(bus.req), 32'h1);
    check("rdA_k6_bus_addr", bus.addr, 32'h200);
    check("rdA_k6_valid", 32'(valid), 32'h0);
    @(negedge clk);
    check("rdA_k7_valid", 32'(valid), 32'h0);
    @(negedge clk);
    check("rdA_k8_valid", 32'(valid), 32'h1);
    check("rdA_k8_head_addr", head_addr, 32'h200);
    check("rdA_k8_rdata", rdata, 32'h1000_0200);

    // Redirect while 0x98 is still ungranted: 0x98 is held, granted, then dropped.
    do_reset(32'h9B);
    gnt_en = 1'b0;
    @(negedge clk);
    check("rdB_k1_bus_addr", bus.addr, 32'h98);
    redirect      = 1'b1;
    redirect_addr = 32'h300;
    @(negedge clk);
    check("rdB_k2_req", 32'(bus.req), 32'h1);
    check("rdB_k2_bus_addr", bus.addr, 32'h98);
    redirect = 1'b0;
    @(negedge clk);
    check("rdB_k3_bus_addr", bus.addr, 32'h98);
    gnt_en = 1'b1;
    @(negedge clk);
    check("rdB_k4_bus_addr", bus.addr, 32'h300);
    @(negedge clk);
    check("rdB_k5_valid", 32'(valid), 32'h0);
    @(negedge clk);
    check("rdB_k6_valid", 32'(valid), 32'h1);
    check("rdB_k6_head_addr", head_addr, 32'h300);

    // Bus error on 0xA0: head carries err with zeroed data, 0xA4 follows normally.
    err_addr = 32'hA0;
    do_reset(32'hA0);
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check("err_k3_valid", 32'(valid), 32'h1);
    check("err_k3_err", 32'(err), 32'h1);
    check("err_k3_rdata", rdata, 32'h0);
    check("err_k3_head_addr", head_addr, 32'hA0);
    ready = 1'b1;
    @(negedge clk);
    check("err_k4_err", 32'(err), 32'h0);
    check("err_k4_head_addr", head_addr, 32'hA4);
    check("err_k4_rdata", rdata, 32'h1000_00A4);
    err_addr = 32'h1;

    // Fetch address wraps from 0xFFFF_FFFC to 0.
    do_reset(32'hFFFF_FFFF);
    @(negedge clk);
    check("wrap_k1_bus_addr", bus.addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_k2_bus_addr", bus.addr, 32'h0);
    @(negedge clk);
    check("wrap_k3_head_addr", head_addr, 32'hFFFF_FFFC);
    check("wrap_k3_rdata", rdata, 32'h0FFF_FFFC);
    @(negedge clk);
    check("wrap_k4_valid", 32'(valid), 32'h1);
    check("wrap_k4_head_addr", head_addr, 32'h0);
    check("wrap_k4_rdata", rdata, 32'h1000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Prefetch unit that owns the instruction-side bus (req/gnt/rvalid) and feeds the IF stage of `cpu_pipeline` with word-aligned instructions and their PCs. It keeps up to `MAX_OUTSTANDING` granted requests in flight, buffers returned words in a small FIFO, and discards stale responses after a branch/jump redirect. It takes over the bus-facing role of `interface_imem`, which lets fetch tolerate multi-cycle memory latency without a combinational bus path.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `MAX_OUTSTANDING`, 2: maximum granted requests without a response, 1..3.

- `CLK` in 1: clock.
- `RST_N` in 1: synchronous, active-low reset.
- `boot_addr_i` in 32: first fetch address after reset; bits [1:0] ignored.
- `redirect_i` in 1: taken branch/jump (pipeline `PC_SEL`).
- `redirect_addr_i` in 32: new fetch address; bits [1:0] ignored.
- `ready_i` in 1: consumer accepts `rdata_o` (pipeline `~STALL`).
- `valid_o` out 1: FIFO head valid.
- `rdata_o` out 32: instruction word at head.
- `addr_o` out 32: PC of head word.
- `err_o` out 1: bus error on head word.
- `busy_o` out 1: any request pending or outstanding.
- `instr_req_o` out 1, `instr_addr_o` out 32, `instr_gnt_i` in 1, `instr_rvalid_i` in 1, `instr_rdata_i` in 32, `instr_err_i` in 1: instruction bus.

## Operation
- Bus rules: `instr_req_o` and `instr_addr_o` are held stable until `instr_gnt_i`. Responses return in order, at least 1 cycle after their grant.
- Request FSM states:
  - `IDLE`: no request on the bus.
  - `WAIT_GNT`: `instr_req_o`=1.
  - Enter `WAIT_GNT` when the credit condition holds: `fifo_count + live_outstanding < DEPTH` and `total_outstanding < MAX_OUTSTANDING`.
  - On grant: `fetch_addr += 4` (32-bit wrap, 0xFFFF_FFFC→0). Stay in `WAIT_GNT` if credit still holds after counting this grant, else go to `IDLE`.
- Counters:
  - `live_outstanding` counts granted requests whose response will be kept.
  - `discard_cnt` counts granted requests whose response will be dropped.
- Responses:
  - On `instr_rvalid_i`, if `discard_cnt`>0, decrement it and drop the data.
  - Otherwise push {rdata, err, addr} into the FIFO and decrement `live_outstanding`. The pushed addr comes from a response-address register that advances by 4 per kept response.
  - `err`=1 entries store `rdata`=0. Fetching continues after an error.
- Pop: `valid_o && ready_i`. Push and pop may occur in the same cycle, including when the FIFO is full.
- Redirect (`redirect_i`=1):
  - Flush the FIFO.
  - `discard_cnt += live_outstanding`; `live_outstanding := 0`.
  - `fetch_addr := redirect_addr_i & ~3`; the response-address register gets the same value.
  - A response arriving in the redirect cycle is dropped (it is stale).
  - A grant in the redirect cycle counts into `discard_cnt`.
  - If `WAIT_GNT` without grant in the redirect cycle: keep the old request asserted (address unchanged) until granted, mark it for discard, then issue the new address.
- Redirect has priority over a same-cycle pop; that pop is lost by design because the pipeline flushes IF/ID.

## Timing
- Reset values: `instr_req_o`=0, `instr_addr_o`=`boot_addr_i`&~3, `valid_o`=0, `rdata_o`=0, `addr_o`=0, `err_o`=0, `busy_o`=0. All counters are 0 and the FSM is in `IDLE`.
- First `instr_req_o` is asserted 1 cycle after `RST_N` rises.
- Response latency: `instr_rvalid_i` at cycle t gives `valid_o` at t+1 (registered FIFO, no bypass).
- Redirect latency: `redirect_i` at t gives `instr_req_o` with the new address at t+1 if no ungranted request is pending. Otherwise the new address appears 1 cycle after the old grant. `valid_o`=0 from t+1 until the first kept response.
- Throughput with 1-cycle memory and `ready_i`=1: 1 word/cycle sustained.
- Reset mid-operation: all state cleared; responses to requests granted before reset are not tracked. The memory side must be reset together with the core.

## Structure
- Shared package `cpu_pkg`: `XLEN`=32, `INSTR_ALIGN_MASK`=32'hFFFF_FFFC, fetch FSM state enum, and the default `DEPTH`/`MAX_OUTSTANDING`.
- One sub-module `prefetch_fifo`: synchronous FIFO, parameterised width (32+1+32) and depth, with flush input, `count` output, and registered head.
- Counters, FSM and address registers live in `instr_prefetch_buffer`.

## Test plan
- Reset release with `boot_addr_i`=0x0000_0080 and zero-wait memory (gnt same cycle, rvalid next) → bus addresses 0x80, 0x84, 0x88…; `valid_o` from cycle 3 with `addr_o`=0x80, then one word per cycle.
- Gnt withheld 3 cycles → `instr_req_o`/`instr_addr_o` (0x84) stable for all 4 cycles; no address advance before gnt.
- `ready_i`=0 with `DEPTH`=4, `MAX_OUTSTANDING`=2 → `fifo_count`+live never exceeds 4 and `instr_req_o` drops; `ready_i`=1 restores requests the next cycle.
- Two requests outstanding (0x90, 0x94), redirect to 0x201 → both responses dropped; next bus addr 0x200; first `valid_o` has `addr_o`=0x200.
- Redirect while request 0x98 is pending ungranted → 0x98 is held until gnt and its response dropped; next request is to the redirect target.
- `instr_err_i`=1 on the response for 0xA0 → head entry `err_o`=1, `rdata_o`=0, `addr_o`=0xA0; 0xA4 is fetched normally.
